rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter_pkg.sv | 16 +
 rtl/rr_mux_arbiter_mux_w.sv | 14 +
 rtl/rr_mux_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared encodings for the round-robin mux arbiter.
// Holds the grant-state encoding and the last-granted markers.
package rr_mux_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G1   = 2'b01,
    ST_G2   = 2'b10
  } state_e;

  localparam logic LAST_1 = 1'b0;
  localparam logic LAST_2 = 1'b1;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/rr_mux_arbiter_mux_w.sv
// Combinational DATA_W-wide 2:1 data select.
// Ports: X1/X2 data in, S select (0 -> X1, 1 -> X2), Y muxed data out.
module mux_w #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] X1,
  input  logic [DATA_W-1:0] X2,
  input  logic              S,
  output logic [DATA_W-1:0] Y
);

  assign Y = S ? X2 : X1;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter driving a registered shared data path.
// Ports: CLK, RST_N (sync, active-low), REQ1/REQ2, X1/X2 in; GNT1/GNT2, S, Y, VALID out.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ1,
  input  logic              REQ2,
  input  logic [DATA_W-1:0] X1,
  input  logic [DATA_W-1:0] X2,
  output logic              GNT1,
  output logic              GNT2,
  output logic              S,
  output logic [DATA_W-1:0] Y,
  output logic              VALID
);

  localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(HOLD_MAX - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               gnt1_q, gnt1_d;
  logic               gnt2_q, gnt2_d;
  logic               s_q, s_d;
  logic [DATA_W-1:0]  y_q, y_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  mux_y;

  mux_w #(.DATA_W(DATA_W)) u_mux (
    .X1 (X1),
    .X2 (X2),
    .S  (s_q),
    .Y  (mux_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ1 && REQ2)
          state_d = (last_q == LAST_1) ? ST_G2 : ST_G1;
        else if (REQ1)
          state_d = ST_G1;
        else if (REQ2)
          state_d = ST_G2;
      end
      ST_G1: begin
        if (!REQ1)
          state_d = REQ2 ? ST_G2 : ST_IDLE;
        else if (REQ2 && cnt_q == HOLD_TOP)
          state_d = ST_G2;
      end
      ST_G2: begin
        if (!REQ2)
          state_d = REQ1 ? ST_G1 : ST_IDLE;
        else if (REQ1 && cnt_q == HOLD_TOP)
          state_d = ST_G1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter restarts on any grant entry/change and saturates so an
  // uncontended owner is never forced off.
  always_comb begin
    cnt_d = '0;
    if (state_d != ST_IDLE && state_d == state_q)
      cnt_d = (cnt_q == HOLD_TOP) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    last_d = last_q;
    if (state_d == ST_G1)
      last_d = LAST_1;
    else if (state_d == ST_G2)
      last_d = LAST_2;
  end

  always_comb begin
    gnt1_d  = (state_d == ST_G1);
    gnt2_d  = (state_d == ST_G2);
    s_d     = s_q;
    if (state_d == ST_G1)
      s_d = 1'b0;
    else if (state_d == ST_G2)
      s_d = 1'b1;
    // Data register only loads while a grant is live, so it
    // retains the last granted word once the path goes idle.
    valid_d = gnt1_q | gnt2_q;
    y_d     = valid_d ? mux_y : y_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_2;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      s_q     <= 1'b0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      s_q     <= s_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign GNT1  = gnt1_q;
  assign GNT2  = gnt2_q;
  assign S     = s_q;
  assign Y     = y_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (DATA_W=8, HOLD_MAX=4).
// Expected values are hand-derived per cycle.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req1, req2;
  logic [7:0] x1, x2;
  logic       gnt1, gnt2, s, valid;
  logic [7:0] y;

  int n_vec;
  int n_err;

  rr_mux_arbiter #(
    .DATA_W   (8),
    .HOLD_MAX (4)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .REQ1  (req1),
    .REQ2  (req2),
    .X1    (x1),
    .X2    (x2),
    .GNT1  (gnt1),
    .GNT2  (gnt2),
    .S     (s),
    .Y     (y),
    .VALID (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic g1, input logic g2,
                         input logic sel, input logic v,
                         input logic [7:0] yy);
    check({tag, ".gnt1"},  32'(gnt1),  32'(g1));
    check({tag, ".gnt2"},  32'(gnt2),  32'(g2));
    check({tag, ".s"},     32'(s),     32'(sel));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".y"},     32'(y),     32'(yy));
  endtask

  initial begin
    logic       eg1;
    logic       prev_s;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req1  = 1'b1;
    req2  = 1'b1;
    x1    = 8'h11;
    x2    = 8'h22;

    tick();
    tick();
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // contention: G1 x4, G2 x4, G1 x4
    rst_n  = 1'b1;
    prev_s = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      eg1 = ((i / 4) % 2) == 0;
      check($sformatf("cont%0d.gnt1", i), 32'(gnt1), 32'(eg1));
      check($sformatf("cont%0d.gnt2", i), 32'(gnt2), 32'(!eg1));
      check($sformatf("cont%0d.s", i),    32'(s),    32'(!eg1));
      if (i == 0) begin
        check("cont0.valid", 32'(valid), 32'd0);
        check("cont0.y",     32'(y),     32'h00);
      end else begin
        check($sformatf("cont%0d.valid", i), 32'(valid), 32'd1);
        check($sformatf("cont%0d.y", i), 32'(y),
              prev_s ? 32'h22 : 32'h11);
      end
      prev_s = !eg1;
    end

    // handoff from G1 straight to G2, then release
    req1 = 1'b0;
    tick();
    chk_out("hand0", 1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
    tick();
    chk_out("hand1", 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);
    req2 = 1'b0;
    tick();
    chk_out("rel0", 1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
    tick();
    chk_out("rel1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);

    // lone requester 2 keeps the grant indefinitely
    x2   = 8'hA5;
    req2 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("solo%0d.gnt2", k), 32'(gnt2), 32'd1);
      check($sformatf("solo%0d.gnt1", k), 32'(gnt1), 32'd0);
      if (k == 0) begin
        check("solo0.valid", 32'(valid), 32'd0);
        check("solo0.y",     32'(y),     32'h22);
      end else begin
        check($sformatf("solo%0d.valid", k), 32'(valid), 32'd1);
        check($sformatf("solo%0d.y", k),     32'(y),     32'hA5);
      end
    end
    req2 = 1'b0;
    tick();
    check("solo_end.gnt2", 32'(gnt2), 32'd0);
    tick();

    // tie after G2 served last goes to requester 1
    req1 = 1'b1;
    req2 = 1'b1;
    tick();
    chk_out("tie_a", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    tick();
    chk_out("tie_b", 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);

    // mid-grant reset pulse
    rst_n = 1'b0;
    tick();
    chk_out("mrst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick();
    chk_out("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // tie after G1 served last goes to requester 2
    req1 = 1'b0;
    req2 = 1'b0;
    tick();
    check("idle.gnt1", 32'(gnt1), 32'd0);
    req1 = 1'b1;
    req2 = 1'b1;
    tick();
    check("tie2.gnt2", 32'(gnt2), 32'd1);
    check("tie2.gnt1", 32'(gnt1), 32'd0);
    check("tie2.s",    32'(s),    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
